prbs_chk: RTL and testbench

PRBS_CHK -- requirements
Module: prbs_chk

---
 rtl/prbs_pkg.sv | 51 +++++
 rtl/prbs_popcount.sv | 18 +
 rtl/prbs_chk.sv | 149 ++++++++++++++
 tb/tb_prbs_chk.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/prbs_pkg.sv
// Shared PRBS definitions: checker FSM states and the LFSR step / word-output
// functions used by both the generator and the checker (widths up to PRBS_MAX_W).
package prbs_pkg;

  localparam int PRBS_MAX_W = 64;

  typedef logic [PRBS_MAX_W-1:0] prbs_vec_t;

  typedef enum logic [1:0] {
    ST_HUNT   = 2'd0,
    ST_VERIFY = 2'd1,
    ST_LOCK   = 2'd2
  } prbs_state_t;

  // Fibonacci LFSR shifting right: state[0] is the next output bit and the
  // feedback (parity of the tapped bits) enters at the top of the pw-bit state.
  // poly must already be masked to its low pw bits.
  function automatic prbs_vec_t lfsr_step(input prbs_vec_t state, input prbs_vec_t poly,
                                          input int pw);
    logic fb;
    fb = ^(state & poly);
    return (state >> 1) | (prbs_vec_t'(fb) << (pw - 1));
  endfunction

  function automatic prbs_vec_t lfsr_advance(input prbs_vec_t state, input prbs_vec_t poly,
                                             input int pw, input int steps);
    prbs_vec_t s;
    s = state;
    for (int k = 0; k < PRBS_MAX_W; k++) begin
      if (k < steps) s = lfsr_step(s, poly, pw);
    end
    return s;
  endfunction

  // First bit in time lands in the word MSB.
  function automatic prbs_vec_t prbs_word(input prbs_vec_t state, input prbs_vec_t poly,
                                          input int pw, input int dw);
    prbs_vec_t s;
    prbs_vec_t w;
    s = state;
    w = '0;
    for (int k = 0; k < PRBS_MAX_W; k++) begin
      if (k < dw) begin
        w = w | (prbs_vec_t'(s[0]) << (dw - 1 - k));
        s = lfsr_step(s, poly, pw);
      end
    end
    return w;
  endfunction

endpackage

// File: rtl/prbs_popcount.sv
// Purely combinational population count of a C_WIDTH-bit vector.
module prbs_popcount #(
  parameter int C_WIDTH = 16
) (
  input  logic [C_WIDTH-1:0]           I_vec,
  output logic [$clog2(C_WIDTH+1)-1:0] O_cnt
);

  localparam int CW = $clog2(C_WIDTH + 1);

  always_comb begin
    O_cnt = '0;
    for (int i = 0; i < C_WIDTH; i++) begin
      O_cnt = O_cnt + CW'(I_vec[i]);
    end
  end

endmodule

// File: rtl/prbs_chk.sv
// PRBS checker: self-synchronising HUNT/VERIFY/LOCK receiver with error counters.
// Define PRBS_CHK_BITCNT_EN to accumulate errored bits instead of errored words.
module prbs_chk
  import prbs_pkg::*;
#(
  parameter int C_DWIDTH     = 16,
  parameter     C_PRIMPOLY   = 17'b1_0001_0000_0000_1011,
  parameter int C_POLY_WIDTH = 16,
  parameter int C_LOCK_CNT   = 4,
  parameter int C_UNLOCK_ERR = 3
) (
  input  logic                          I_clk,
  input  logic                          I_rst,
  input  logic [C_DWIDTH-1:0]           I_prbs,
  input  logic                          I_prbs_v,
  input  logic                          I_clr,
  output logic                          O_lock,
  output logic                          O_err_v,
  output logic [$clog2(C_DWIDTH+1)-1:0] O_err_bits,
  output logic [31:0]                   O_err_cnt,
  output logic [31:0]                   O_word_cnt
);

  localparam int CW = $clog2(C_DWIDTH + 1);
  localparam int MW = $clog2(C_LOCK_CNT + 1);
  localparam int EW = $clog2(C_UNLOCK_ERR + 1);
  localparam prbs_vec_t POLY_V = prbs_vec_t'(C_PRIMPOLY[C_POLY_WIDTH-1:0]);

  prbs_state_t             state_q, state_d;
  logic [C_POLY_WIDTH-1:0] exp_q, exp_d, seed, seed_adv, exp_adv;
  logic [MW-1:0]           match_q, match_d;
  logic [EW-1:0]           cerr_q, cerr_d;
  logic [C_DWIDTH-1:0]     x_word, mask;
  logic [CW-1:0]           pop, err_bits_d;
  logic                    mask_zero, lock_d, err_v_d;
  logic [31:0]             err_cnt_d, word_cnt_d;
  logic [32:0]             err_add, err_sum;

  // The first bit in time of the word is the oldest LFSR state bit.
  for (genvar j = 0; j < C_POLY_WIDTH; j++) begin : g_seed
    assign seed[j] = I_prbs[C_DWIDTH-1-j];
  end

  assign seed_adv  = C_POLY_WIDTH'(lfsr_advance(prbs_vec_t'(seed), POLY_V, C_POLY_WIDTH, C_DWIDTH));
  assign exp_adv   = C_POLY_WIDTH'(lfsr_advance(prbs_vec_t'(exp_q), POLY_V, C_POLY_WIDTH, C_DWIDTH));
  assign x_word    = C_DWIDTH'(prbs_word(prbs_vec_t'(exp_q), POLY_V, C_POLY_WIDTH, C_DWIDTH));
  assign mask      = I_prbs ^ x_word;
  assign mask_zero = (mask == '0);

  prbs_popcount #(.C_WIDTH(C_DWIDTH)) u_popcount (
    .I_vec(mask),
    .O_cnt(pop)
  );

`ifdef PRBS_CHK_BITCNT_EN
  assign err_add = 33'(pop);
`else
  assign err_add = 33'd1;
`endif
  assign err_sum = {1'b0, O_err_cnt} + err_add;

  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      state_q    <= ST_HUNT;
      exp_q      <= '0;
      match_q    <= '0;
      cerr_q     <= '0;
      O_lock     <= 1'b0;
      O_err_v    <= 1'b0;
      O_err_bits <= '0;
      O_err_cnt  <= '0;
      O_word_cnt <= '0;
    end else begin
      state_q    <= state_d;
      exp_q      <= exp_d;
      match_q    <= match_d;
      cerr_q     <= cerr_d;
      O_lock     <= lock_d;
      O_err_v    <= err_v_d;
      O_err_bits <= err_bits_d;
      O_err_cnt  <= err_cnt_d;
      O_word_cnt <= word_cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (I_prbs_v) begin
      case (state_q)
        ST_HUNT:   state_d = ST_VERIFY;
        ST_VERIFY: if (mask_zero && match_q == MW'(C_LOCK_CNT - 1)) state_d = ST_LOCK;
        ST_LOCK:   if (!mask_zero && cerr_q == EW'(C_UNLOCK_ERR - 1)) state_d = ST_HUNT;
        default:   state_d = ST_HUNT;
      endcase
    end
  end

  // A mismatch while verifying means a bad seed, so restart from the current word.
  always_comb begin
    exp_d      = exp_q;
    match_d    = match_q;
    cerr_d     = cerr_q;
    err_v_d    = 1'b0;
    err_bits_d = O_err_bits;
    err_cnt_d  = O_err_cnt;
    word_cnt_d = O_word_cnt;
    if (I_prbs_v) begin
      case (state_q)
        ST_HUNT: begin
          exp_d   = seed_adv;
          match_d = '0;
          cerr_d  = '0;
        end
        ST_VERIFY: begin
          err_bits_d = pop;
          cerr_d     = '0;
          if (mask_zero) begin
            exp_d   = exp_adv;
            match_d = match_q + MW'(1);
          end else begin
            exp_d   = seed_adv;
            match_d = '0;
          end
        end
        ST_LOCK: begin
          err_bits_d = pop;
          exp_d      = exp_adv;
          word_cnt_d = (O_word_cnt == 32'hFFFF_FFFF) ? O_word_cnt : O_word_cnt + 32'd1;
          if (mask_zero) begin
            cerr_d = '0;
          end else begin
            err_v_d   = 1'b1;
            err_cnt_d = err_sum[32] ? 32'hFFFF_FFFF : err_sum[31:0];
            cerr_d    = cerr_q + EW'(1);
          end
        end
        default: begin
          exp_d = exp_q;
        end
      endcase
    end
    if (I_clr) begin
      err_cnt_d  = '0;
      word_cnt_d = '0;
    end
    lock_d = (state_d == ST_LOCK);
  end

endmodule

// File: tb/tb_prbs_chk.sv
// Directed bench for prbs_chk: an independent x^16+x^12+x^3+x+1 generator
// feeds the checker; expectations are hand-derived per scenario.
module tb_prbs_chk;

  logic        I_clk = 1'b0;
  logic        I_rst;
  logic [15:0] I_prbs;
  logic        I_prbs_v;
  logic        I_clr;
  logic        O_lock;
  logic        O_err_v;
  logic [4:0]  O_err_bits;
  logic [31:0] O_err_cnt;
  logic [31:0] O_word_cnt;

  int          total = 0;
  int          bad = 0;
  logic [15:0] gen_st;

`ifdef PRBS_CHK_BITCNT_EN
  localparam int EXP_INV_ERR = 48;
`else
  localparam int EXP_INV_ERR = 3;
`endif

  prbs_chk dut (
    .I_clk     (I_clk),
    .I_rst     (I_rst),
    .I_prbs    (I_prbs),
    .I_prbs_v  (I_prbs_v),
    .I_clr     (I_clr),
    .O_lock    (O_lock),
    .O_err_v   (O_err_v),
    .O_err_bits(O_err_bits),
    .O_err_cnt (O_err_cnt),
    .O_word_cnt(O_word_cnt)
  );

  always #5 I_clk = ~I_clk;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change on the falling edge; outputs are read on the next falling edge.
  task automatic applyStimulus(input logic [15:0] w, input logic v, input logic clr, input logic rst);
    I_prbs   = w;
    I_prbs_v = v;
    I_clr    = clr;
    I_rst    = rst;
    @(negedge I_clk);
  endtask

  task automatic genWord(output logic [15:0] w);
    logic fb;
    for (int k = 0; k < 16; k++) begin
      w[15-k] = gen_st[0];
      fb      = gen_st[0] ^ gen_st[1] ^ gen_st[3] ^ gen_st[12];
      gen_st  = {fb, gen_st[15:1]};
    end
  endtask

  task automatic sendGen(input logic [15:0] flip, input logic clr);
    logic [15:0] w;
    genWord(w);
    applyStimulus(w ^ flip, 1'b1, clr, 1'b0);
  endtask

  task automatic checkZero(input string tag);
    checkOutput({tag, "_lock"},     64'(O_lock),     64'd0);
    checkOutput({tag, "_err_v"},    64'(O_err_v),    64'd0);
    checkOutput({tag, "_err_bits"}, 64'(O_err_bits), 64'd0);
    checkOutput({tag, "_err_cnt"},  64'(O_err_cnt),  64'd0);
    checkOutput({tag, "_word_cnt"}, 64'(O_word_cnt), 64'd0);
  endtask

  // One seed word plus four matches; lock only appears after the fifth.
  task automatic lockUp(input string tag);
    for (int i = 1; i <= 5; i++) begin
      sendGen(16'h0000, 1'b0);
      checkOutput($sformatf("%s_lock_w%0d", tag, i), 64'(O_lock), (i == 5) ? 64'd1 : 64'd0);
    end
  endtask

  initial begin
    int          lock_drops;
    int          stray_err;
    logic [15:0] w;

    I_rst    = 1'b1;
    I_prbs   = '0;
    I_prbs_v = 1'b0;
    I_clr    = 1'b0;
    gen_st   = 16'h0001;
    @(negedge I_clk);
    applyStimulus(16'h1234, 1'b1, 1'b1, 1'b1);
    applyStimulus(16'h0000, 1'b0, 1'b0, 1'b1);
    checkZero("reset");

    lockUp("acq");
    checkOutput("acq_err_cnt",  64'(O_err_cnt),  64'd0);
    checkOutput("acq_word_cnt", 64'(O_word_cnt), 64'd0);

    for (int i = 6; i <= 9; i++) sendGen(16'h0000, 1'b0);
    checkOutput("clean_word_cnt", 64'(O_word_cnt), 64'd4);
    sendGen(16'h0008, 1'b0);
    checkOutput("flip_err_v",    64'(O_err_v),    64'd1);
    checkOutput("flip_err_bits", 64'(O_err_bits), 64'd1);
    checkOutput("flip_err_cnt",  64'(O_err_cnt),  64'd1);
    checkOutput("flip_lock",     64'(O_lock),     64'd1);
    checkOutput("flip_word_cnt", 64'(O_word_cnt), 64'd5);
    sendGen(16'h0000, 1'b0);
    checkOutput("after_flip_err_v",    64'(O_err_v),    64'd0);
    checkOutput("after_flip_err_bits", 64'(O_err_bits), 64'd0);
    checkOutput("after_flip_lock",     64'(O_lock),     64'd1);

    applyStimulus(16'h0000, 1'b0, 1'b1, 1'b0);
    checkOutput("clr_err_cnt",  64'(O_err_cnt),  64'd0);
    checkOutput("clr_word_cnt", 64'(O_word_cnt), 64'd0);
    checkOutput("clr_lock",     64'(O_lock),     64'd1);

    sendGen(16'hFFFF, 1'b0);
    checkOutput("inv1_err_v",    64'(O_err_v),    64'd1);
    checkOutput("inv1_err_bits", 64'(O_err_bits), 64'd16);
    checkOutput("inv1_lock",     64'(O_lock),     64'd1);
    sendGen(16'hFFFF, 1'b0);
    checkOutput("inv2_lock",     64'(O_lock),     64'd1);
    sendGen(16'hFFFF, 1'b0);
    checkOutput("inv3_lock",     64'(O_lock),     64'd0);
    checkOutput("inv3_err_cnt",  64'(O_err_cnt),  64'(EXP_INV_ERR));
    checkOutput("inv3_word_cnt", 64'(O_word_cnt), 64'd3);
    lockUp("relock");
    checkOutput("relock_err_cnt",  64'(O_err_cnt),  64'(EXP_INV_ERR));
    checkOutput("relock_word_cnt", 64'(O_word_cnt), 64'd3);

    applyStimulus(16'h0000, 1'b0, 1'b1, 1'b0);
    lock_drops = 0;
    stray_err  = 0;
    for (int n = 0; n < 20; n++) begin
      int gaps;
      gaps = int'($urandom_range(0, 5));
      for (int g = 0; g < gaps; g++) begin
        applyStimulus(16'hA5A5, 1'b0, 1'b0, 1'b0);
        if (O_lock !== 1'b1) lock_drops++;
        if (O_err_v !== 1'b0) stray_err++;
      end
      sendGen(16'h0000, 1'b0);
      if (O_lock !== 1'b1) lock_drops++;
      if (O_err_v !== 1'b0) stray_err++;
    end
    checkOutput("gap_lock_drops", 64'(lock_drops), 64'd0);
    checkOutput("gap_err_pulses", 64'(stray_err),  64'd0);
    checkOutput("gap_word_cnt",   64'(O_word_cnt), 64'd20);
    checkOutput("gap_err_cnt",    64'(O_err_cnt),  64'd0);

    sendGen(16'h0100, 1'b0);
    checkOutput("pre_clr_err_cnt",  64'(O_err_cnt),  64'd1);
    checkOutput("pre_clr_word_cnt", 64'(O_word_cnt), 64'd21);
    sendGen(16'h0002, 1'b1);
    checkOutput("clr_err_word_err_cnt",  64'(O_err_cnt),  64'd0);
    checkOutput("clr_err_word_word_cnt", 64'(O_word_cnt), 64'd0);
    checkOutput("clr_err_word_lock",     64'(O_lock),     64'd1);
    sendGen(16'h0000, 1'b0);
    checkOutput("post_clr_lock",     64'(O_lock),     64'd1);
    checkOutput("post_clr_word_cnt", 64'(O_word_cnt), 64'd1);

    genWord(w);
    applyStimulus(w, 1'b1, 1'b0, 1'b1);
    checkZero("rst_pulse");
    lockUp("post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
